// File: rtl/conv_pkg.sv
`default_nettype none
// conv_pkg -- sizing helpers and a signed compare shared by the conv/pool stages.
// Rev 1.0
package conv_pkg;

  localparam int DEF_DATA_WIDTH  = 16;
  localparam int DEF_KERNEL_SIZE = 5;
  localparam int DEF_IMAGE_SIZE  = 28;

  // Widest operand signed_max accepts; narrower callers sign-extend into it.
  localparam int MAX_W = 64;

  function automatic int conv_size(input int image_size, input int kernel_size);
    return image_size - kernel_size + 1;
  endfunction

  function automatic int pool_size(input int csize);
    return csize / 2;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [MAX_W-1:0] signed_max(
    input logic signed [MAX_W-1:0] a,
    input logic signed [MAX_W-1:0] b
  );
    return (a >= b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_line_buffer.sv
`default_nettype none
// pool_line_buffer -- half-row store of horizontal pair maxima; no reset.
// Rev 1.0
module pool_line_buffer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = 12,
  parameter int ADDR_W     = 4
) (
  input  logic                         clk,
  input  logic                         i_wr_en,
  input  logic [ADDR_W-1:0]            i_addr,
  input  logic signed [DATA_WIDTH-1:0] i_wr_data,
  output logic signed [DATA_WIDTH-1:0] o_rd_data
);

  logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/conv_maxpool_2x2.sv
`default_nettype none
// conv_maxpool_2x2 -- on-the-fly 2x2 stride-2 max pool of a row-major conv stream.
// Rev 1.0
module conv_maxpool_2x2
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int IMAGE_SIZE  = DEF_IMAGE_SIZE
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic                         frame_done
);

  localparam int CONV_SIZE = conv_size(IMAGE_SIZE, KERNEL_SIZE);
  localparam int POOL_SIZE = pool_size(CONV_SIZE);
  localparam int CNT_W     = cnt_width(CONV_SIZE);
  localparam int ADDR_W    = CNT_W - 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(CONV_SIZE - 1);

  generate
    if ((CONV_SIZE % 2) != 0 || CONV_SIZE < 4) begin : g_bad_size
      $error("conv_maxpool_2x2: CONV_SIZE must be even and at least 4");
    end
  endgenerate

  function automatic logic signed [DATA_WIDTH-1:0] max_d(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [MAX_W-1:0] w_a;
    logic signed [MAX_W-1:0] w_m;
    w_a = {{(MAX_W-DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
    w_m = signed_max(w_a, {{(MAX_W-DATA_WIDTH){b[DATA_WIDTH-1]}}, b});
    return (w_m == w_a) ? a : b;
  endfunction

  logic [CNT_W-1:0]              r_col;
  logic [CNT_W-1:0]              r_row;
  logic signed [DATA_WIDTH-1:0]  r_h;
  logic                          r_out_valid;
  logic signed [DATA_WIDTH-1:0]  r_out_data;
  logic                          r_frame_done;

  logic signed [DATA_WIDTH-1:0]  w_pair;
  logic signed [DATA_WIDTH-1:0]  w_lb_rd;
  logic                          w_lb_we;
  logic [ADDR_W-1:0]             w_lb_addr;

  assign w_pair    = max_d(r_h, in_data);
  assign w_lb_we   = in_valid & r_col[0] & ~r_row[0];
  assign w_lb_addr = r_col[CNT_W-1:1];

  pool_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (POOL_SIZE),
    .ADDR_W     (ADDR_W)
  ) u_line_buf (
    .clk       (clk),
    .i_wr_en   (w_lb_we),
    .i_addr    (w_lb_addr),
    .i_wr_data (w_pair),
    .o_rd_data (w_lb_rd)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col        <= '0;
      r_row        <= '0;
      r_h          <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      if (in_valid) begin
        if (!r_col[0]) begin
          r_h <= in_data;
        end else if (r_row[0]) begin
          // Fourth sample of the window: fold in the pair stored on the even row.
          r_out_data   <= max_d(w_lb_rd, w_pair);
          r_out_valid  <= 1'b1;
          r_frame_done <= (r_row == C_LAST) && (r_col == C_LAST);
        end
        if (r_col == C_LAST) begin
          r_col <= '0;
          r_row <= (r_row == C_LAST) ? '0 : r_row + CNT_W'(1);
        end else begin
          r_col <= r_col + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_maxpool_2x2.sv
`default_nettype none
// tb_conv_maxpool_2x2 -- directed vectors for the 2x2 max-pool stage.
// Rev 1.0
module tb_conv_maxpool_2x2;

  localparam int DW = 16;
  localparam int CS = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rstn;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic                 frame_done;

  logic                 in_valid6;
  logic signed [DW-1:0] in_data6;
  logic                 out_valid6;
  logic signed [DW-1:0] out_data6;
  logic                 frame_done6;

  conv_maxpool_2x2 #(.DATA_WIDTH(DW), .KERNEL_SIZE(5), .IMAGE_SIZE(28)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .frame_done(frame_done)
  );

  conv_maxpool_2x2 #(.DATA_WIDTH(DW), .KERNEL_SIZE(3), .IMAGE_SIZE(8)) dut6 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid6), .in_data(in_data6),
    .out_valid(out_valid6), .out_data(out_data6), .frame_done(frame_done6)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  int q_data[$];
  int q_fd[$];
  int q_cyc[$];
  int e_data[$];
  int e_fd[$];
  int e_cyc[$];

  always @(negedge clk) begin
    if (out_valid) begin
      q_data.push_back(int'(out_data));
      q_fd.push_back(int'(frame_done));
      q_cyc.push_back(cyc);
    end
  end

  typedef struct {
    logic signed [DW-1:0] data;
    int                   gap;
    logic                 exp_ov;
    logic signed [DW-1:0] exp_od;
    logic                 exp_fd;
  } vec_t;

  vec_t tbl[36];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int gen(input int mode, input int off, input int r, input int c);
    if (mode == 0) return off + r * CS + c;
    return (r == 2 && c == 3) ? -1 : -5;
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic drive_frame(input int mode, input int off, input int off_cycles, input int stop_after);
    for (int r = 0; r < CS; r++) begin
      for (int c = 0; c < CS; c++) begin
        if (r * CS + c > stop_after) return;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = DW'(gen(mode, off, r, c));
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          e_data.push_back(max4(gen(mode, off, r-1, c-1), gen(mode, off, r-1, c),
                                gen(mode, off, r, c-1),   gen(mode, off, r, c)));
          e_fd.push_back((r == CS-1 && c == CS-1) ? 1 : 0);
          e_cyc.push_back(cyc + 1);
        end
        repeat (off_cycles) begin
          @(posedge clk); #1;
          in_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic drain();
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string tag, input int qb);
    int n;
    n = q_data.size() - qb;
    chk({tag, " pulse count"}, n, e_data.size());
    for (int i = 0; i < e_data.size() && i < n; i++) begin
      chk($sformatf("%s out[%0d] data", tag, i), q_data[qb+i], e_data[i]);
      chk($sformatf("%s out[%0d] frame_done", tag, i), q_fd[qb+i], e_fd[i]);
      chk($sformatf("%s out[%0d] cycle", tag, i), q_cyc[qb+i], e_cyc[i]);
    end
  endtask

  task automatic clear_expect();
    e_data.delete();
    e_fd.delete();
    e_cyc.delete();
  endtask

  initial begin
    int qb;
    int nfd;
    int pooled6[9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
    int last6;
    logic hit;

    // Hand-computed vectors for the 6x6 variant: out_data holds between pulses.
    last6 = 0;
    for (int k = 0; k < 36; k++) begin
      hit = 1'b0;
      for (int j = 0; j < 9; j++) if (pooled6[j] == k) hit = 1'b1;
      if (hit) last6 = k;
      tbl[k].data   = DW'(k);
      tbl[k].gap    = (k % 7 == 3) ? 2 : 0;
      tbl[k].exp_ov = hit;
      tbl[k].exp_od = DW'(last6);
      tbl[k].exp_fd = (k == 35);
    end

    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_valid6 = 1'b0;
    in_data6  = '0;
    #1;
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_data", int'(out_data), 0);
    chk("reset frame_done", int'(frame_done), 0);
    chk("reset6 out_valid", int'(out_valid6), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // 6x6 variant from the table.
    for (int i = 0; i < 36; i++) begin
      in_valid6 = 1'b1;
      in_data6  = tbl[i].data;
      @(posedge clk); @(negedge clk);
      chk($sformatf("v6[%0d] out_valid", i), int'(out_valid6), int'(tbl[i].exp_ov));
      chk($sformatf("v6[%0d] out_data", i), int'(out_data6), int'(tbl[i].exp_od));
      chk($sformatf("v6[%0d] frame_done", i), int'(frame_done6), int'(tbl[i].exp_fd));
      if (tbl[i].gap > 0) begin
        in_valid6 = 1'b0;
        repeat (tbl[i].gap) begin
          @(posedge clk); @(negedge clk);
          chk($sformatf("v6[%0d] stall out_valid", i), int'(out_valid6), 0);
          chk($sformatf("v6[%0d] stall out_data", i), int'(out_data6), int'(tbl[i].exp_od));
        end
      end
    end
    in_valid6 = 1'b0;

    // Ramp, continuous.
    clear_expect();
    qb = q_data.size();
    drive_frame(0, 0, 0, CS*CS-1);
    drain();
    check_outputs("ramp", qb);
    if (q_data.size() - qb >= 144) begin
      chk("ramp first", q_data[qb], 25);
      chk("ramp second", q_data[qb+1], 27);
      chk("ramp last", q_data[qb+143], 575);
    end

    // Negative frame with one larger sample.
    clear_expect();
    qb = q_data.size();
    drive_frame(1, 0, 0, CS*CS-1);
    drain();
    check_outputs("neg", qb);
    if (q_data.size() - qb >= 144) begin
      chk("neg pooled(1,1)", q_data[qb+13], -1);
      chk("neg pooled(0,0)", q_data[qb], -5);
    end

    // Ramp with 1-on/3-off stalls.
    clear_expect();
    qb = q_data.size();
    drive_frame(0, 0, 3, CS*CS-1);
    drain();
    check_outputs("stall", qb);

    // Mid-frame asynchronous reset after sample 300.
    clear_expect();
    drive_frame(0, 0, 0, 300);
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    chk("pre-reset out_data", int'(out_data), 287);
    rstn = 1'b0;
    #1;
    chk("async reset out_valid", int'(out_valid), 0);
    chk("async reset out_data", int'(out_data), 0);
    chk("async reset frame_done", int'(frame_done), 0);
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b1;
    clear_expect();
    qb = q_data.size();
    drive_frame(0, 0, 0, CS*CS-1);
    drain();
    check_outputs("post-reset", qb);

    // Two frames back to back.
    clear_expect();
    qb = q_data.size();
    drive_frame(0, 0, 0, CS*CS-1);
    drive_frame(0, 1000, 0, CS*CS-1);
    drain();
    check_outputs("b2b", qb);
    nfd = 0;
    for (int i = qb; i < q_fd.size(); i++) nfd += q_fd[i];
    chk("b2b frame_done count", nfd, 2);
    if (q_data.size() - qb >= 288) begin
      chk("b2b frame2 first", q_data[qb+144], 1025);
      chk("b2b frame2 last", q_data[qb+287], 1575);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_maxpool_2x2.md
Name: conv_maxpool_2x2

Overview:
- Downstream neighbour of the convolver datapath/controlpath.
- Consumes the valid convolution result stream, qualified by the controlpath `enable` strobe. That stream is row-major, (IMAGE_SIZE-KERNEL_SIZE+1)² samples per frame.
- Produces a 2x2 stride-2 max-pooled stream of ((IMAGE_SIZE-KERNEL_SIZE+1)/2)² samples per frame.
- Uses one line buffer of half-row width, so it pools on the fly without storing the frame.

Parameters:
- DATA_WIDTH, 16, width of the signed two's-complement samples in and out.
- KERNEL_SIZE, 5, convolution kernel edge; used only to derive the conv output size.
- IMAGE_SIZE, 28, input image edge; CONV_SIZE = IMAGE_SIZE-KERNEL_SIZE+1 (24).

Ports:
- clk, input, 1: rising-edge clock.
- rstn, input, 1: asynchronous active-low reset.
- in_valid, input, 1: sample strobe; driven from the controlpath `enable`.
- in_data, input, DATA_WIDTH: signed conv result; sampled only when in_valid=1.
- out_valid, output, 1: one-cycle pulse per pooled sample.
- out_data, output, DATA_WIDTH: signed pooled max; valid when out_valid=1.
- frame_done, output, 1: one-cycle pulse coincident with the last pooled sample of a frame.

Behaviour:
- Reset: clk and rstn only; reset is asynchronous, active-low.
  - Asserting rstn=0 clears col, row, h_reg, out_valid, out_data and frame_done to 0 immediately.
  - Line buffer contents are don't-care after reset; they are always written before being read.
  - Reset mid-frame abandons the partial frame. The next accepted sample is treated as (row 0, col 0).
- Sizing:
  - CONV_SIZE must be even; an odd value is an elaboration-time error.
  - POOL_SIZE = CONV_SIZE/2.
- Counters: col and row each run 0..CONV_SIZE-1, width clog2(CONV_SIZE).
  - Both advance only on in_valid=1.
  - col wraps at CONV_SIZE-1 and increments row.
  - row wraps at CONV_SIZE-1 with col, then the next frame starts with no idle cycle.
- Stall: in_valid=0 holds all state; gaps of any length between samples are legal.
- Even col: h_reg <= in_data.
- Odd col: pair = signed max(h_reg, in_data), computed combinationally.
  - Even row: linebuf[col>>1] <= pair.
  - Odd row: out_data <= signed max(linebuf[col>>1], pair); out_valid <= 1 on the next edge.
- Latency: out_valid rises exactly 1 cycle after the in_valid cycle that accepts the 4th sample of a window (odd row, odd col).
- Output spacing:
  - out_valid is 0 on every other cycle.
  - Outputs are at least 2 accepted samples apart and are never back-to-back.
  - No downstream backpressure; the consumer must accept every pulse.
- frame_done <= 1 together with out_valid for the window at row=col=CONV_SIZE-1; otherwise 0.
- Comparisons: full DATA_WIDTH signed, no saturation or rounding. On ties either operand is correct since the values are equal.
- out_data holds its last value between pulses.

Decomposition:
- Shared package `conv_pkg`:
  - CONV_SIZE and POOL_SIZE derivation functions.
  - Counter width constants (clog2).
  - A signed_max function, reusable by later pooling/activation stages.
- One sub-module, `pool_line_buffer`:
  - POOL_SIZE x DATA_WIDTH register array.
  - One write port and one asynchronous read port, addressed by col>>1.
  - Has no reset.

Test Plan:
1. Ramp: in_data = k for k=0..575, in_valid=1 every cycle.
   - 144 out_valid pulses.
   - Pooled (r,c) = (2r+1)*24+2c+1: first value 25, second 27, last 575.
   - frame_done only with 575.
2. Negative values: frame all -5 except conv (2,3) = -1.
   - Pooled (1,1) = -1; every other output = -5, which checks the signed compare.
3. Stall: same ramp as scenario 1, with in_valid toggled 1 cycle on / 3 off.
   - Identical 144-value sequence.
   - Each out_valid 1 cycle after its 4th sample.
4. Mid-frame reset: assert rstn=0 after sample 300 (async, off clock edge).
   - Outputs go to 0 immediately.
   - A fresh ramp after release yields the scenario 1 results exactly.
5. Back-to-back frames: two ramps (second offset +1000) with no gap.
   - 288 outputs; frame_done twice.
   - Second frame first value 1025, last 1575.
6. Parameter variant: IMAGE_SIZE=8, KERNEL_SIZE=3 (CONV_SIZE=6), ramp 0..35.
   - Outputs 7, 9, 11, 19, 21, 23, 31, 33, 35.
